// File: rtl/tmds_encoder.sv
// DVI 1.0 TMDS 8b/10b encoder for one channel: stage 1 minimises transitions,
// stage 2 balances running disparity and muxes in control symbols.
module tmds_encoder (
  input  logic       i_pixclk,
  input  logic       i_rst,
  input  logic       i_de,
  input  logic [7:0] i_data,
  input  logic       i_c0,
  input  logic       i_c1,
  output logic [9:0] o_tmds
);

  // No handshake: one input word accepted and one output word produced every
  // cycle; valid is implied on every clock and there is never backpressure.

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  logic [8:0]        qm_q, qm_d;
  logic [3:0]        n1_q, n1_d;
  logic              de_q, de_d;
  logic              c0_q, c0_d;
  logic              c1_q, c1_d;
  logic signed [4:0] cnt_q, cnt_d;
  logic [9:0]        tmds_q, tmds_d;

  logic [3:0]        n1_data;
  logic              use_xnor;

  always_comb begin
    logic [7:0] chain;
    n1_data  = ones8(i_data);
    use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !i_data[0]);
    chain    = '0;
    chain[0] = i_data[0];
    for (int i = 1; i < 8; i++) begin
      chain[i] = use_xnor ? ~(chain[i-1] ^ i_data[i]) : (chain[i-1] ^ i_data[i]);
    end
    qm_d = {~use_xnor, chain};
    // Ones count of q_m is registered here so stage 2 starts from a flop.
    n1_d = ones8(chain);
    de_d = i_de;
    c0_d = i_c0;
    c1_d = i_c1;
  end

  logic signed [4:0] n1_s, n0_s, diff_s, two_qm8, two_nqm8;

  always_comb begin
    n1_s     = signed'({1'b0, n1_q});
    n0_s     = 5'sd8 - n1_s;
    diff_s   = n1_s - n0_s;
    two_qm8  = qm_q[8] ? 5'sd2 : 5'sd0;
    two_nqm8 = qm_q[8] ? 5'sd0 : 5'sd2;
    tmds_d   = 10'h354;
    cnt_d    = cnt_q;
    if (!de_q) begin
      cnt_d = 5'sd0;
      case ({c1_q, c0_q})
        2'b00:   tmds_d = 10'h354;
        2'b01:   tmds_d = 10'h0AB;
        2'b10:   tmds_d = 10'h154;
        default: tmds_d = 10'h2AB;
      endcase
    end else if ((cnt_q == 5'sd0) || (n1_s == n0_s)) begin
      tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d  = qm_q[8] ? (cnt_q + diff_s) : (cnt_q - diff_s);
    end else if (((cnt_q > 5'sd0) && (n1_s > n0_s)) ||
                 ((cnt_q < 5'sd0) && (n0_s > n1_s))) begin
      tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d  = cnt_q + two_qm8 - diff_s;
    end else begin
      tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d  = cnt_q - two_nqm8 + diff_s;
    end
  end

  // Cleared stage 1 decodes as a 00 control symbol, so reset drains as 10'h354.
  always_ff @(posedge i_pixclk) begin
    if (i_rst) begin
      qm_q   <= '0;
      n1_q   <= '0;
      de_q   <= 1'b0;
      c0_q   <= 1'b0;
      c1_q   <= 1'b0;
      cnt_q  <= 5'sd0;
      tmds_q <= 10'h354;
    end else begin
      qm_q   <= qm_d;
      n1_q   <= n1_d;
      de_q   <= de_d;
      c0_q   <= c0_d;
      c1_q   <= c1_d;
      cnt_q  <= cnt_d;
      tmds_q <= tmds_d;
    end
  end

  assign o_tmds = tmds_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: directed vector table, then a long random stream
// checked against a disparity-based model of the DVI 1.0 encoding rules.
module tb_tmds_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       de;
  logic [7:0] data;
  logic       c0, c1;
  logic [9:0] tmds;

  int n_vec  = 0;
  int n_fail = 0;

  tmds_encoder dut (
    .i_pixclk(clk),
    .i_rst   (rst),
    .i_de    (de),
    .i_data  (data),
    .i_c0    (c0),
    .i_c1    (c1),
    .o_tmds  (tmds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic [9:0] exp_tmds;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[18];

  // Model state: running disparity after the newest input, and the
  // word/disparity pair still travelling through stage 1.
  int         m_cnt;
  logic [9:0] m_pend_w;
  int         m_pend_cnt;
  logic [9:0] m_out_w;
  int         m_out_cnt;

  task automatic check_word(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: o_tmds=%h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] ctrl_word(input logic [1:0] c);
    logic [9:0] tbl [4];
    tbl[0] = 10'h354; tbl[1] = 10'h0AB; tbl[2] = 10'h154; tbl[3] = 10'h2AB;
    return tbl[c];
  endfunction

  // Inverts q_m when that pulls the running disparity back toward zero;
  // disparity is then simply the ones-minus-zeros of the emitted word.
  function automatic logic [9:0] model_word(input logic [7:0] d, input int cnt);
    int         n1;
    logic       xn;
    logic [8:0] qm;
    int         bal;
    logic       inv;
    n1    = $countones(d);
    xn    = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xn;
    bal   = 2 * $countones(qm[7:0]) - 8;
    if (cnt == 0 || bal == 0) inv = ~qm[8];
    else                      inv = ((cnt > 0) == (bal > 0));
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic [7:0] d, input logic [1:0] c);
    logic [9:0] w;
    if (r) begin
      m_out_w = 10'h354; m_out_cnt = 0;
      m_pend_w = 10'h354; m_pend_cnt = 0; m_cnt = 0;
    end else begin
      m_out_w   = m_pend_w;
      m_out_cnt = m_pend_cnt;
      if (e) begin
        w     = model_word(d, m_cnt);
        m_cnt = m_cnt + 2 * $countones(w) - 10;
      end else begin
        w     = ctrl_word(c);
        m_cnt = 0;
      end
      m_pend_w   = w;
      m_pend_cnt = m_cnt;
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [7:0] d, input logic [1:0] c);
    rst  = r;
    de   = e;
    data = d;
    {c1, c0} = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   got_cnt;
    logic r, e;
    logic [7:0] d;
    logic [1:0] c;

    rst = 1'b1; de = 1'b0; data = '0; c0 = 1'b0; c1 = 1'b0;
    m_cnt = 0; m_pend_w = 10'h354; m_pend_cnt = 0; m_out_w = 10'h354; m_out_cnt = 0;

    // Each row: inputs for this edge, o_tmds/cnt expected just after it.
    vecs[0]  = '{1'b1, 1'b1, 8'hA5, 2'b00, 10'h354,  0};
    vecs[1]  = '{1'b1, 1'b1, 8'hA5, 2'b00, 10'h354,  0};
    vecs[2]  = '{1'b1, 1'b1, 8'hA5, 2'b00, 10'h354,  0};
    vecs[3]  = '{1'b0, 1'b1, 8'hA5, 2'b00, 10'h354,  0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 2'b00, 10'h163,  0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 2'b01, 10'h354,  0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 2'b10, 10'h0AB,  0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 2'b11, 10'h154,  0};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 2'b00, 10'h2AB,  0};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 2'b00, 10'h100, -8};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 2'b00, 10'h3FF,  2};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 2'b00, 10'h100, -6};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 2'b00, 10'h354,  0};
    vecs[13] = '{1'b0, 1'b1, 8'hFF, 2'b00, 10'h354,  0};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 2'b00, 10'h200, -8};
    vecs[15] = '{1'b0, 1'b1, 8'hFF, 2'b00, 10'h354,  0};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 2'b00, 10'h200, -8};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 2'b00, 10'h354,  0};

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].de, vecs[i].data, vecs[i].ctrl);
      got_cnt = dut.cnt_q;
      check_word($sformatf("table_tmds[%0d]", i), tmds, vecs[i].exp_tmds);
      check_int($sformatf("table_cnt[%0d]", i), got_cnt, vecs[i].exp_cnt);
    end

    // Random stream; row 0 resets so model and DUT share a start point,
    // and row 7000 forces a mid-stream reset besides the random ones.
    for (int i = 0; i < 20000; i++) begin
      r = (i == 0) || (i == 7000) || ($urandom_range(0, 1499) == 0);
      e = ($urandom_range(0, 7) != 0);
      d = 8'($urandom_range(0, 255));
      c = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) d = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      model_edge(r, e, d, c);
      drive(r, e, d, c);
      got_cnt = dut.cnt_q;
      check_word("rand_tmds", tmds, m_out_w);
      check_int("rand_cnt", got_cnt, m_out_cnt);
      n_vec++;
      if (got_cnt > 8 || got_cnt < -8) begin
        n_fail++;
        $display("FAIL cnt_bound: cnt=%0d exceeds magnitude 8 at %0t", got_cnt, $time);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
